// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, line levels, command/response
// codes and the microsecond-to-cycle conversion used to size timers.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQUEST   = 3'd2,
    ST_WAIT_EDGE = 3'd3,
    ST_SHIFT     = 3'd4,
    ST_DRAIN     = 3'd5,
    ST_RESULT    = 3'd6
  } ps2_tx_state_t;

  localparam logic YES  = 1'b1;
  localparam logic NO   = 1'b0;
  localparam logic LOW  = 1'b0;
  localparam logic HIGH = 1'b1;

  localparam logic [7:0] COMMAND_SET_LEDS      = 8'hED;
  localparam logic [7:0] SCAN_CODE_ACKNOWLEDGE = 8'hFA;
  localparam logic [7:0] SCAN_CODE_SELF_TEST   = 8'hAA;

  function automatic int ps2_us_to_cycles(input int clk_hz, input int us);
    return (clk_hz / 1_000_000) * us;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for the raw PS/2 clock and data pins, plus a registered
// falling-edge strobe on the synchronised clock. Shared by transmitter and receiver.
module ps2_line_sync
  import ps2_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic line_clk,
  input  logic line_data,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  logic clk_meta;
  logic data_meta;

  // Idle bus is high, so reset the chain high to avoid a false edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_meta  <= HIGH;
      data_meta <= HIGH;
      clk_sync  <= HIGH;
      data_sync <= HIGH;
      clk_fall  <= NO;
    end else begin
      clk_meta  <= line_clk;
      data_meta <= line_data;
      clk_sync  <= clk_meta;
      data_sync <= data_meta;
      clk_fall  <= clk_sync & ~clk_meta;
    end
  end

endmodule

// File: rtl/ps2_command_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 11-bit frame shifted on device
// clock falls, ack check, and one ack/error result per accepted command byte.
module ps2_command_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 15_000
) (
  input  logic       clk,
  input  logic       reset,
  output logic       command_ready,
  input  logic       command_valid,
  input  logic [7:0] command_byte,
  input  logic       command_ack_ready,
  output logic       command_ack_valid,
  output logic       command_ack_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low,
  output logic       transmitting
);

  localparam int INHIBIT_CYCLES = ps2_us_to_cycles(CLK_HZ, INHIBIT_US);
  localparam int TIMEOUT_CYCLES = ps2_us_to_cycles(CLK_HZ, TIMEOUT_US);
  localparam int INHIBIT_W      = $clog2(INHIBIT_CYCLES + 1);
  localparam int TIMEOUT_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INHIBIT_W-1:0] INHIBIT_LAST  = INHIBIT_W'(INHIBIT_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);

  ps2_tx_state_t        state;
  logic [8:0]           shift;
  logic [3:0]           bit_count;
  logic                 ack_fail;
  logic [INHIBIT_W-1:0] inhibit_count;
  logic [TIMEOUT_W-1:0] timeout_count;
  logic                 clk_sync;
  logic                 data_sync;
  logic                 clk_fall;
  logic                 timed_state;

  ps2_line_sync u_line_sync (
    .clk       (clk),
    .reset     (reset),
    .line_clk  (ps2_clk_in),
    .line_data (ps2_data_in),
    .clk_sync  (clk_sync),
    .data_sync (data_sync),
    .clk_fall  (clk_fall)
  );

  assign command_ready = (state == ST_IDLE);
  assign transmitting  = (state != ST_IDLE) && (state != ST_RESULT);
  assign timed_state   = (state == ST_WAIT_EDGE) || (state == ST_SHIFT) || (state == ST_DRAIN);

  // Frame sequencer, shift register, timers and registered line/result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= ST_IDLE;
      shift              <= 9'd0;
      bit_count          <= 4'd0;
      ack_fail           <= NO;
      inhibit_count      <= '0;
      timeout_count      <= '0;
      ps2_clk_drive_low  <= NO;
      ps2_data_drive_low <= NO;
      command_ack_valid  <= NO;
      command_ack_error  <= NO;
    end else begin
      if (timed_state) begin
        if (clk_fall) begin
          timeout_count <= '0;
        end else if (timeout_count != TIMEOUT_LIMIT) begin
          timeout_count <= timeout_count + 1'b1;
        end
      end

      if (timed_state && (timeout_count == TIMEOUT_LIMIT)) begin
        ps2_clk_drive_low  <= NO;
        ps2_data_drive_low <= NO;
        command_ack_valid  <= YES;
        command_ack_error  <= YES;
        state              <= ST_RESULT;
      end else begin
        case (state)
          ST_IDLE: begin
            if (command_valid) begin
              shift             <= {~^command_byte, command_byte};
              inhibit_count     <= '0;
              ps2_clk_drive_low <= YES;
              state             <= ST_INHIBIT;
            end
          end
          ST_INHIBIT: begin
            if (inhibit_count == INHIBIT_LAST) begin
              ps2_data_drive_low <= YES;
              state              <= ST_REQUEST;
            end else begin
              inhibit_count <= inhibit_count + 1'b1;
            end
          end
          ST_REQUEST: begin
            ps2_clk_drive_low <= NO;
            timeout_count     <= '0;
            bit_count         <= 4'd0;
            state             <= ST_WAIT_EDGE;
          end
          ST_WAIT_EDGE, ST_SHIFT: begin
            if (clk_fall) begin
              if (bit_count == 4'd10) begin
                ack_fail           <= data_sync;
                ps2_data_drive_low <= NO;
                state              <= ST_DRAIN;
              end else begin
                // Ones shift in behind the parity bit, so fall 10 releases data as the stop bit.
                ps2_data_drive_low <= ~shift[0];
                shift              <= {1'b1, shift[8:1]};
                bit_count          <= bit_count + 4'd1;
                state              <= ST_SHIFT;
              end
            end
          end
          ST_DRAIN: begin
            if (clk_sync && data_sync) begin
              command_ack_valid <= YES;
              command_ack_error <= ack_fail;
              state             <= ST_RESULT;
            end
          end
          ST_RESULT: begin
            if (command_ack_ready) begin
              command_ack_valid <= NO;
              state             <= ST_IDLE;
            end
          end
          default: begin
            ps2_clk_drive_low  <= NO;
            ps2_data_drive_low <= NO;
            command_ack_valid  <= NO;
            state              <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_command_tx.sv
// Directed bench for ps2_command_tx: a table of acked/nacked frames driven by an
// open-collector device model, plus sequences for timeout, backpressure and reset.
module tb_ps2_command_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       command_ready;
  logic       command_valid;
  logic [7:0] command_byte;
  logic       command_ack_ready;
  logic       command_ack_valid;
  logic       command_ack_error;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_drive_low;
  logic       ps2_data_drive_low;
  logic       transmitting;
  logic       dev_clk_low;
  logic       dev_data_low;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] cmd;
    logic       ack;
    logic       exp_parity;
    logic       exp_error;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  // Wired-AND open-collector bus.
  assign ps2_clk_in  = ~(ps2_clk_drive_low | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_drive_low | dev_data_low);

  ps2_command_tx #(
    .CLK_HZ     (1_000_000),
    .INHIBIT_US (100),
    .TIMEOUT_US (2000)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .command_ready      (command_ready),
    .command_valid      (command_valid),
    .command_byte       (command_byte),
    .command_ack_ready  (command_ack_ready),
    .command_ack_valid  (command_ack_valid),
    .command_ack_error  (command_ack_error),
    .ps2_clk_in         (ps2_clk_in),
    .ps2_data_in        (ps2_data_in),
    .ps2_clk_drive_low  (ps2_clk_drive_low),
    .ps2_data_drive_low (ps2_data_drive_low),
    .transmitting       (transmitting)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [7:0] cmd);
    int n = 0;
    while (!command_ready && n < 5000) begin
      step();
      n++;
    end
    check("ready_before_accept", 32'(command_ready), 32'd1);
    command_valid = 1'b1;
    command_byte  = cmd;
    step();
    command_valid = 1'b0;
  endtask

  task automatic check_request();
    int n = 0;
    while (ps2_clk_drive_low && !ps2_data_drive_low && n < 1000) begin
      n++;
      step();
    end
    check("inhibit_cycles", 32'(n), 32'd100);
    check("request_clk_low", 32'(ps2_clk_drive_low), 32'd1);
    check("request_data_low", 32'(ps2_data_drive_low), 32'd1);
    step();
    check("wait_clk_released", 32'(ps2_clk_drive_low), 32'd0);
    check("wait_data_held", 32'(ps2_data_drive_low), 32'd1);
    check("wait_transmitting", 32'(transmitting), 32'd1);
  endtask

  task automatic dev_pulses(input int n, input logic ack, output logic [9:0] bits);
    bits = 10'd0;
    repeat (10) @(posedge clk);
    for (int i = 1; i <= n; i++) begin
      if (i == 11) begin
        #1 dev_data_low = ack;
        repeat (3) @(posedge clk);
      end
      #1 dev_clk_low = 1'b1;
      repeat (25) @(posedge clk);
      #1 dev_clk_low = 1'b0;
      if (i <= 10) bits[i-1] = ps2_data_in;
      repeat (25) @(posedge clk);
    end
    #1 dev_data_low = 1'b0;
  endtask

  task automatic wait_result(output int cyc);
    cyc = 0;
    while (!command_ack_valid && cyc < 5000) begin
      step();
      cyc++;
    end
    check("ack_valid_seen", 32'(command_ack_valid), 32'd1);
    check("result_not_transmitting", 32'(transmitting), 32'd0);
  endtask

  task automatic take_result();
    command_ack_ready = 1'b1;
    step();
    command_ack_ready = 1'b0;
    check("ack_valid_cleared", 32'(command_ack_valid), 32'd0);
    check("ready_after_take", 32'(command_ready), 32'd1);
  endtask

  task automatic frame_checks(input vec_t v, input logic [9:0] bits);
    check("frame_data", 32'(bits[7:0]), 32'(v.cmd));
    check("frame_parity", 32'(bits[8]), 32'(v.exp_parity));
    check("frame_stop", 32'(bits[9]), 32'd1);
  endtask

  task automatic full_frame(input vec_t v);
    logic [9:0] bits;
    int cyc;
    accept(v.cmd);
    check_request();
    dev_pulses(11, v.ack, bits);
    frame_checks(v, bits);
    wait_result(cyc);
    check("ack_error", 32'(command_ack_error), 32'(v.exp_error));
    take_result();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] bits;
    int cyc;
    vec_t v;

    vecs[0] = '{cmd: 8'hED, ack: 1'b1, exp_parity: 1'b1, exp_error: 1'b0};
    vecs[1] = '{cmd: 8'h00, ack: 1'b1, exp_parity: 1'b1, exp_error: 1'b0};
    vecs[2] = '{cmd: 8'h07, ack: 1'b1, exp_parity: 1'b0, exp_error: 1'b0};
    vecs[3] = '{cmd: 8'hFF, ack: 1'b1, exp_parity: 1'b1, exp_error: 1'b0};
    vecs[4] = '{cmd: 8'hF4, ack: 1'b0, exp_parity: 1'b0, exp_error: 1'b1};
    vecs[5] = '{cmd: 8'hA5, ack: 1'b1, exp_parity: 1'b1, exp_error: 1'b0};

    reset             = 1'b1;
    command_valid     = 1'b0;
    command_byte      = 8'h00;
    command_ack_ready = 1'b0;
    dev_clk_low       = 1'b0;
    dev_data_low      = 1'b0;
    repeat (3) step();
    check("reset_ready", 32'(command_ready), 32'd1);
    check("reset_ack_valid", 32'(command_ack_valid), 32'd0);
    check("reset_ack_error", 32'(command_ack_error), 32'd0);
    check("reset_clk_drive", 32'(ps2_clk_drive_low), 32'd0);
    check("reset_data_drive", 32'(ps2_data_drive_low), 32'd0);
    check("reset_transmitting", 32'(transmitting), 32'd0);
    reset = 1'b0;
    step();

    // Acked frames, parity corners, a nack, and a normal frame after the nack.
    for (int i = 0; i < 6; i++) full_frame(vecs[i]);

    // Device never clocks: timeout result.
    accept(8'hF2);
    check_request();
    wait_result(cyc);
    check("timeout_window", 32'((cyc >= 1990) && (cyc <= 2010)), 32'd1);
    check("timeout_error", 32'(command_ack_error), 32'd1);
    check("timeout_clk_released", 32'(ps2_clk_drive_low), 32'd0);
    check("timeout_data_released", 32'(ps2_data_drive_low), 32'd0);
    take_result();

    // Backpressure on the result channel with a competing command.
    v = '{cmd: 8'hFF, ack: 1'b1, exp_parity: 1'b1, exp_error: 1'b0};
    accept(v.cmd);
    check_request();
    dev_pulses(11, 1'b1, bits);
    frame_checks(v, bits);
    wait_result(cyc);
    command_valid = 1'b1;
    command_byte  = 8'h00;
    for (int i = 0; i < 50; i++) begin
      step();
      check("bp_ack_valid", 32'(command_ack_valid), 32'd1);
      check("bp_ack_error", 32'(command_ack_error), 32'd0);
      check("bp_ready_low", 32'(command_ready), 32'd0);
      check("bp_not_started", 32'(ps2_clk_drive_low), 32'd0);
    end
    command_ack_ready = 1'b1;
    step();
    command_ack_ready = 1'b0;
    check("bp_taken", 32'(command_ack_valid), 32'd0);
    check("bp_ready_rises", 32'(command_ready), 32'd1);
    step();
    command_valid = 1'b0;
    check("bp_second_accepted", 32'(ps2_clk_drive_low), 32'd1);
    v = '{cmd: 8'h00, ack: 1'b1, exp_parity: 1'b1, exp_error: 1'b0};
    check_request();
    dev_pulses(11, 1'b1, bits);
    frame_checks(v, bits);
    wait_result(cyc);
    check("bp_second_error", 32'(command_ack_error), 32'd0);
    take_result();

    // Reset while data bit 4 (a zero of 8'hED) is on the line.
    accept(8'hED);
    check_request();
    dev_pulses(5, 1'b1, bits);
    check("d4_presented", 32'(ps2_data_drive_low), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset_clk_drive", 32'(ps2_clk_drive_low), 32'd0);
    check("midreset_data_drive", 32'(ps2_data_drive_low), 32'd0);
    check("midreset_ready", 32'(command_ready), 32'd1);
    check("midreset_ack_valid", 32'(command_ack_valid), 32'd0);
    step();
    full_frame(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
